// File: rtl/axi_st_patgen_multi.sv
// -----------------------------------------------------------------------------
// axi_st_patgen_multi
//   Multi-lane AXI-ST pattern generator for AIB link bring-up and loopback.
//   NUM_LANE independent lane generators (fixed / LFSR / increment /
//   walking-one) feed an internal FIFO. A one-entry output register drains the
//   FIFO onto a valid/ready stream with full backpressure. Every generated word
//   is also mirrored on exp_data/exp_wr for the checker FIFO.
//
//   Optional build macro: PATGEN_TLAST_EN adds a tlast output, carried through
//   the FIFO as an extra bit.
//
// Ports
//   wr_clk, rst_n      clock, synchronous active-low reset
//   start              pulse, launches a burst when idle
//   cont_en            continuous mode, run until deasserted
//   mode[1:0]          00 fixed, 01 LFSR, 10 increment, 11 walking-one
//   burst_len          beats per burst (ignored in continuous mode)
//   seed               base seed
//   chkr_full          checker FIFO full, stalls generation
//   tdata/tvalid/tready stream; lane k at [k*LANE_W +: LANE_W]
//   tlast              (PATGEN_TLAST_EN only) last beat of burst
//   exp_data/exp_wr    expected-data mirror and write strobe
//   busy               high while generating or draining
//   done               one-cycle pulse when the burst is fully accepted
//   beat_cnt           accepted beats in the current/last burst (saturating)
// -----------------------------------------------------------------------------
module axi_st_patgen_multi #(
  parameter int NUM_LANE   = 2,
  parameter int LANE_W     = 40,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                       wr_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cont_en,
  input  logic [1:0]                 mode,
  input  logic [CNT_W-1:0]           burst_len,
  input  logic [LANE_W-1:0]          seed,
  input  logic                       chkr_full,
  output logic [NUM_LANE*LANE_W-1:0] tdata,
  output logic                       tvalid,
  input  logic                       tready,
  output logic [NUM_LANE*LANE_W-1:0] exp_data,
  output logic                       exp_wr,
  output logic                       busy,
  output logic                       done,
`ifdef PATGEN_TLAST_EN
  output logic                       tlast,
`endif
  output logic [CNT_W-1:0]           beat_cnt
);

  localparam int DW = NUM_LANE * LANE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PATGEN_TLAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif

  // Taps 40,38,21,19 for the 40-bit lane; other widths use W,W-2,W-3,W-4.
  localparam logic [LANE_W-1:0] LFSR_TAPS = (LANE_W == 40) ?
    ((LANE_W'(1) << 39) | (LANE_W'(1) << 37) | (LANE_W'(1) << 20) | (LANE_W'(1) << 18)) :
    ((LANE_W'(1) << (LANE_W-1)) | (LANE_W'(1) << (LANE_W-3)) |
     (LANE_W'(1) << (LANE_W-4)) | (LANE_W'(1) << (LANE_W-5)));

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_t;

  function automatic logic [LANE_W-1:0] lane_init(input logic [1:0] m,
                                                  input logic [LANE_W-1:0] s,
                                                  input int unsigned k);
    logic [LANE_W-1:0] v;
    v = s;
    case (m)
      2'b01: begin
        v = s ^ LANE_W'(k);
        if (v == '0) v = LANE_W'(1);
      end
      2'b10:   v = s + LANE_W'(k);
      2'b11:   v = LANE_W'(1) << (k % LANE_W);
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic [LANE_W-1:0] lane_step(input logic [1:0] m,
                                                  input logic [LANE_W-1:0] x);
    logic [LANE_W-1:0] v;
    case (m)
      2'b01:   v = {x[LANE_W-2:0], ^(x & LFSR_TAPS)};
      2'b10:   v = x + LANE_W'(1);
      2'b11:   v = {x[LANE_W-2:0], x[LANE_W-1]};
      default: v = x;
    endcase
    return v;
  endfunction

  state_t               r_state, w_next;
  logic [1:0]           r_mode;
  logic                 r_cont;
  logic [CNT_W-1:0]     r_len;
  logic [CNT_W-1:0]     r_gen_cnt;
  logic [LANE_W-1:0]    r_lane [NUM_LANE];
  logic [DW-1:0]        w_word;
  logic [FW-1:0]        w_push_data;

  logic [FW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_full, w_empty;

  logic [DW-1:0]        r_tdata;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic [DW-1:0]        r_exp_data;
  logic                 r_exp_wr;
  logic                 r_done;
  logic [CNT_W-1:0]     r_beat_cnt;

  logic                 w_start_ok, w_zero_burst;
  logic                 w_gen, w_gen_end, w_drained;
  logic                 w_pop, w_pop_ok, w_mark, w_hs;

  assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_drained    = w_empty && !r_tvalid;
  assign w_hs         = r_tvalid && tready;
  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_zero_burst = w_start_ok && (burst_len == '0) && !cont_en;
  assign w_gen_end    = r_cont ? !cont_en : (r_gen_cnt == r_len);

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < NUM_LANE; k++) begin
      w_word[k*LANE_W +: LANE_W] = r_lane[k];
    end
  end

`ifdef PATGEN_TLAST_EN
  assign w_push_data = {(!r_cont && ((r_gen_cnt + CNT_W'(1)) == r_len)), w_word};
  // In continuous mode the newest word is kept in the FIFO until either a
  // further word is generated or cont_en falls, so its tlast bit can still be
  // set once it is known to be the final word.
  assign w_pop_ok = (r_count != (AW+1)'(1)) || w_gen || !((r_state == S_GEN) && r_cont);
  assign w_mark   = (r_state == S_GEN) && r_cont && !cont_en && !w_empty;
`else
  assign w_push_data = w_word;
  assign w_pop_ok    = 1'b1;
  assign w_mark      = 1'b0;
`endif

  assign w_pop = !w_empty && (!r_tvalid || tready) && w_pop_ok;

  // FSM state register
  always_ff @(posedge wr_clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state and generate strobe
  always_comb begin
    w_next = r_state;
    w_gen  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !((burst_len == '0) && !cont_en)) w_next = S_GEN;
      end
      S_GEN: begin
        if (w_gen_end) w_next = S_DRAIN;
        else           w_gen  = !w_full && !chkr_full;
      end
      S_DRAIN: begin
        if (w_drained) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Burst configuration and lane generators
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_mode    <= '0;
      r_cont    <= 1'b0;
      r_len     <= '0;
      r_gen_cnt <= '0;
      for (int unsigned k = 0; k < NUM_LANE; k++) r_lane[k] <= '0;
    end else if (w_start_ok) begin
      r_mode    <= mode;
      r_cont    <= cont_en;
      r_len     <= burst_len;
      r_gen_cnt <= '0;
      for (int unsigned k = 0; k < NUM_LANE; k++) r_lane[k] <= lane_init(mode, seed, k);
    end else if (w_gen) begin
      r_gen_cnt <= r_gen_cnt + CNT_W'(1);
      for (int unsigned k = 0; k < NUM_LANE; k++) r_lane[k] <= lane_step(r_mode, r_lane[k]);
    end
  end

  // FIFO storage (contents need no reset; occupancy is tracked by r_count)
  always_ff @(posedge wr_clk) begin
    if (w_gen)  r_mem[r_wr_ptr] <= w_push_data;
    if (w_mark) r_mem[r_wr_ptr - AW'(1)][FW-1] <= 1'b1;
  end

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_gen) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_gen, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register, expected-data mirror, status
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_exp_data <= '0;
      r_exp_wr   <= 1'b0;
      r_done     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_tdata  <= r_mem[r_rd_ptr][DW-1:0];
        r_tlast  <= r_mem[r_rd_ptr][FW-1];
        r_tvalid <= 1'b1;
      end else if (tready) begin
        r_tvalid <= 1'b0;
      end
      r_exp_wr <= w_gen;
      if (w_gen) r_exp_data <= w_word;
      r_done <= ((r_state == S_DRAIN) && w_drained) || w_zero_burst;
      if (w_start_ok)                     r_beat_cnt <= '0;
      else if (w_hs && (r_beat_cnt != '1)) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign tdata    = r_tdata;
  assign tvalid   = r_tvalid;
  assign exp_data = r_exp_data;
  assign exp_wr   = r_exp_wr;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign beat_cnt = r_beat_cnt;
`ifdef PATGEN_TLAST_EN
  assign tlast    = r_tlast;
`else
  logic w_unused;
  assign w_unused = r_tlast;
`endif

endmodule

// File: tb/tb_axi_st_patgen_multi.sv
module tb_axi_st_patgen_multi;

  localparam int NL = 2;
  localparam int LW = 40;
  localparam int FD = 16;
  localparam int CW = 16;
  localparam int DW = NL * LW;
  localparam logic [LW-1:0] TAPMASK = 40'h00_0000_0001 << 39 | 40'h00_0000_0001 << 37 |
                                     40'h00_0000_0001 << 20 | 40'h00_0000_0001 << 18;

  logic          wr_clk = 1'b0;
  logic          rst_n, start, cont_en, chkr_full, tready;
  logic [1:0]    mode;
  logic [CW-1:0] burst_len;
  logic [LW-1:0] seed;
  logic [DW-1:0] tdata, exp_data;
  logic          tvalid, exp_wr, busy, done;
  logic [CW-1:0] beat_cnt;
`ifdef PATGEN_TLAST_EN
  logic          tlast;
`endif

  axi_st_patgen_multi #(.NUM_LANE(NL), .LANE_W(LW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .start(start), .cont_en(cont_en), .mode(mode),
    .burst_len(burst_len), .seed(seed), .chkr_full(chkr_full), .tdata(tdata),
    .tvalid(tvalid), .tready(tready), .exp_data(exp_data), .exp_wr(exp_wr),
    .busy(busy), .done(done),
`ifdef PATGEN_TLAST_EN
    .tlast(tlast),
`endif
    .beat_cnt(beat_cnt));

  always #5 wr_clk = ~wr_clk;

  int n_vec = 0, n_err = 0;

  // Reference model state
  int            m_mode, m_len;
  logic          m_cont;
  logic [LW-1:0] m_seed;
  int            tx_idx, ex_idx, done_cnt, cyc, last_hs, done_cyc, tv_cnt, last_cnt;
  logic          last_tl, prev_stall, rnd_full;
  logic [DW-1:0] prev_tdata, first_word;
  int            rdy_mode, rdy_pct;

  // Value of lane k on beat j, straight from the pattern definitions.
  function automatic logic [LW-1:0] lane_val(int m, logic [LW-1:0] s, int k, int j);
    logic [LW-1:0] x;
    case (m)
      1: begin
        x = s ^ LW'(k);
        if (x == 0) x = 1;
        for (int i = 0; i < j; i++) x = (x << 1) | LW'(^(x & TAPMASK));
      end
      2:       x = s + LW'(k) + LW'(j);
      3:       x = LW'(1) << ((k + j) % LW);
      default: x = s;
    endcase
    return x;
  endfunction

  function automatic logic [DW-1:0] word(int j);
    logic [DW-1:0] w;
    for (int k = 0; k < NL; k++) w[k*LW +: LW] = lane_val(m_mode, m_seed, k, j);
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then return 1 time unit after
  // the rising edge with the next tready value applied.
  task automatic step();
    @(negedge wr_clk);
    cyc++;
    if (rst_n) begin
      if (prev_stall) chk("hold", 128'({tvalid, tdata}), 128'({1'b1, prev_tdata}));
      if (tvalid) tv_cnt++;
      if (tvalid && tready) begin
        if (tx_idx == 0) first_word = tdata;
        chk("tdata", 128'(tdata), 128'(word(tx_idx)));
`ifdef PATGEN_TLAST_EN
        if (!m_cont) chk("tlast", 128'(tlast), 128'(tx_idx + 1 == m_len));
        last_cnt += int'(tlast);
        last_tl = tlast;
`endif
        tx_idx++;
        last_hs = cyc;
      end
      if (exp_wr) begin
        chk("exp_data", 128'(exp_data), 128'(word(ex_idx)));
        ex_idx++;
        chk("occupancy", 128'(ex_idx - tx_idx <= FD + 1), 128'(1));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = tvalid && !tready;
      prev_tdata = tdata;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge wr_clk);
    #1;
    case (rdy_mode)
      1:       tready = (cyc % 3 == 0);
      2:       tready = (int'($urandom_range(99)) < rdy_pct);
      default: tready = 1'b1;
    endcase
    if (rnd_full) chkr_full = ($urandom_range(3) == 0);
  endtask

  task automatic launch(input int md, input logic [LW-1:0] sd, input int len, input logic ct);
    m_mode = md; m_seed = sd; m_len = len; m_cont = ct;
    tx_idx = 0; ex_idx = 0; done_cnt = 0; tv_cnt = 0; last_cnt = 0; last_tl = 0;
    mode = 2'(md); seed = sd; burst_len = CW'(len); cont_en = ct;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    chk("done_seen", 128'(done_cnt != 0), 128'(1));
    repeat (3) step();
    chk("done_once", 128'(done_cnt), 128'(1));
    chk("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic run_burst(input int md, input logic [LW-1:0] sd, input int len);
    launch(md, sd, len, 1'b0);
    wait_done(4000);
    chk("beats_tx", 128'(tx_idx), 128'(len));
    chk("beats_exp", 128'(ex_idx), 128'(len));
    chk("beat_cnt", 128'(beat_cnt), 128'(len));
  endtask

  typedef struct {
    int            md;
    logic [LW-1:0] sd;
    int            len;
    int            rmode;
    int            pct;
    logic [LW-1:0] f0;
    logic [LW-1:0] f1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, e0, d0;
    rst_n = 0; start = 0; cont_en = 0; chkr_full = 0; tready = 1; rnd_full = 0;
    mode = 0; burst_len = 0; seed = 0; rdy_mode = 0; rdy_pct = 100;
    cyc = 0; prev_stall = 0; m_mode = 0; m_seed = 0; m_len = 0; m_cont = 0;
    tx_idx = 0; ex_idx = 0; done_cnt = 0; tv_cnt = 0; last_cnt = 0; last_tl = 0;

    tbl[0] = '{2, 40'd0,             4,  0, 100, 40'd0,             40'd1};
    tbl[1] = '{1, 40'd0,             64, 0, 100, 40'd1,             40'd1};
    tbl[2] = '{2, 40'd0,             40, 1, 0,   40'd0,             40'd1};
    tbl[3] = '{0, 40'h12_3456_789A,  5,  2, 50,  40'h12_3456_789A,  40'h12_3456_789A};
    tbl[4] = '{3, 40'd0,             45, 2, 70,  40'd1,             40'd2};
    tbl[5] = '{2, 40'hFF_FFFF_FFFF,  3,  0, 100, 40'hFF_FFFF_FFFF,  40'd0};
    tbl[6] = '{1, 40'd5,             10, 0, 100, 40'd5,             40'd4};
    tbl[7] = '{2, 40'd0,             0,  0, 100, 40'd0,             40'd0};

    // Reset state
    repeat (3) step();
    chk("rst_data", 128'({tdata, tvalid, exp_wr, busy, done}), 128'(0));
    chk("rst_exp", 128'({exp_data, beat_cnt}), 128'(0));
    rst_n = 1;
    step();

    // Latency and done timing: increment, 4 beats, always ready
    launch(2, 40'd0, 4, 1'b0);
    lat = 0;
    while (tv_cnt == 0 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 128'(lat), 128'(3));
    wait_done(100);
    chk("done_gap", 128'(done_cyc - last_hs), 128'(2));
    chk("t1_beat_cnt", 128'(beat_cnt), 128'(4));

    // Table-driven bursts
    for (int i = 0; i < 8; i++) begin
      rdy_mode = tbl[i].rmode;
      rdy_pct  = tbl[i].pct;
      run_burst(tbl[i].md, tbl[i].sd, tbl[i].len);
      if (tbl[i].len == 0) begin
        chk("zero_no_valid", 128'(tv_cnt), 128'(0));
      end else begin
        chk("first_lane0", 128'(first_word[0 +: LW]), 128'(tbl[i].f0));
        chk("first_lane1", 128'(first_word[LW +: LW]), 128'(tbl[i].f1));
      end
    end

    // Randomized bursts with random backpressure and checker stalls
    rnd_full = 1;
    for (int i = 0; i < 8; i++) begin
      rdy_mode = 2;
      rdy_pct  = int'($urandom_range(100, 25));
      run_burst(int'($urandom_range(3)), {$urandom, $urandom}, int'($urandom_range(30, 1)));
    end
    rnd_full = 0;
    chkr_full = 0;
    rdy_mode = 0;

    // Continuous mode with a checker-full stall
    launch(2, 40'd100, 7, 1'b1);
    repeat (15) step();
    chkr_full = 1;
    step();
    e0 = ex_idx;
    repeat (10) step();
    chk("stall_no_expwr", 128'(ex_idx - e0), 128'(0));
    chkr_full = 0;
    repeat (10) step();
    cont_en = 0;
    wait_done(200);
    chk("cont_tx_eq_exp", 128'(tx_idx), 128'(ex_idx));
    chk("cont_beat_cnt", 128'(beat_cnt), 128'(tx_idx));
    chk("cont_progress", 128'(ex_idx > 20), 128'(1));
`ifdef PATGEN_TLAST_EN
    chk("cont_tlast_cnt", 128'(last_cnt), 128'(1));
    chk("cont_tlast_end", 128'(last_tl), 128'(1));
`endif

    // Reset in the middle of a 20-beat burst
    launch(2, 40'd0, 20, 1'b0);
    lat = 0;
    while (tx_idx < 5 && lat < 60) begin
      step();
      lat++;
    end
    chk("reached_beat5", 128'(tx_idx >= 5), 128'(1));
    rst_n = 0;
    d0 = done_cnt;
    step();
    chk("midrst_data", 128'({tdata, tvalid, exp_wr, busy, done}), 128'(0));
    chk("midrst_exp", 128'({exp_data, beat_cnt}), 128'(0));
    rst_n = 1;
    repeat (6) step();
    chk("midrst_no_done", 128'(done_cnt), 128'(d0));
    chk("midrst_idle", 128'({tvalid, busy}), 128'(0));

`ifdef PATGEN_TLAST_EN
    // Walking-one with tlast on the final beat
    run_burst(3, 40'd0, 3);
    chk("wk_lane0", 128'(first_word[0 +: LW]), 128'(1));
    chk("wk_tlast_cnt", 128'(last_cnt), 128'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
